// File: rtl/rca_word_sequencer.sv
// Multi-cycle wide adder: one N-bit ripple-carry slice per clock, LSB slice first.
// Optional subtract mode (a - b, op port) is compiled in with `define RCA_SEQ_SUB_EN.

module ripple_carry_adder_using_parameter #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule

module rca_word_sequencer #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef RCA_SEQ_SUB_EN
  input  logic                 op,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [W-1:0]     b_load;
  logic             carry_load;
  logic [N-1:0]     slice_sum;
  logic             slice_cout;

  // Subtraction is a + ~b + 1, so it reuses the adder with no extra datapath.
`ifdef RCA_SEQ_SUB_EN
  assign b_load     = op ? ~b : b;
  assign carry_load = op ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  ripple_carry_adder_using_parameter #(.N(N)) u_slice (
    .a    (a_q[idx_q*N +: N]),
    .b    (b_q[idx_q*N +: N]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b_load;
          carry_d    = carry_load;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        sum_d[idx_q*N +: N] = slice_sum;
        carry_d             = slice_cout;
        idx_d               = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d      = slice_cout;
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  // The operand registers are reset too, so a mid-RUN abort leaves no stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Self-checking bench for rca_word_sequencer: directed cases plus random
// back-to-back traffic compared against an arithmetic reference model.

module tb_rca_word_sequencer;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef RCA_SEQ_SUB_EN
  logic         op;
`endif

  int total = 0;
  int bad   = 0;

  rca_word_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef RCA_SEQ_SUB_EN
    .op        (op),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: W+1-bit result of the whole-word operation.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic sub);
    logic [W:0] r;
    if (sub) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else     r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    return r;
  endfunction

  // Called at a negedge while IDLE; returns at the negedge after the accept edge.
  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc, input logic sub);
    a        = xa;
    b        = xb;
    cin      = xc;
`ifdef RCA_SEQ_SUB_EN
    op       = sub;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
    check("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_handoff", out_valid, 0);
    check("in_ready_after_handoff", in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input logic sub);
    int lat;
    logic [W:0] exp;
    exp = model(xa, xb, xc, sub);
    start_op(xa, xb, xc, sub);
    wait_done(lat);
    check({tag, "_latency"}, 64'(lat), 64'(WORDS));
    check({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
    check({tag, "_cout"}, 64'(cout), 64'(exp[W]));
    finish_op();
  endtask

  initial begin
    int lat;
    logic [W:0] exp;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    op        = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", 64'(sum), 0);
    check("reset_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    run_op("t_carry_mid", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b0);

    // Backpressure: result must hold while in_valid and operands churn.
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_done(lat);
    check("bp_latency", 64'(lat), 64'(WORDS));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp_sum", 64'(sum), 64'h2345_6789);
      check("bp_cout", cout, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    finish_op();
    @(negedge clk);
    check("bp_no_accept", in_ready, 1);

    // Asynchronous reset after two RUN edges aborts with no result.
    start_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_sum", 64'(sum), 0);
    check("rst_mid_cout", cout, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", in_ready, 1);
    check("rst_release_out_valid", out_valid, 0);
    run_op("post_rst", 32'h8000_0001, 32'h8000_FFFF, 1'b1, 1'b0);

`ifdef RCA_SEQ_SUB_EN
    run_op("sub_borrow", 32'd5, 32'd7, 1'b1, 1'b1);
    check("sub_borrow_const", 64'(model(32'd5, 32'd7, 1'b1, 1'b1)), 64'h0_FFFF_FFFE);
    run_op("sub_noborrow", 32'd7, 32'd5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      run_op("sub_rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`endif

    // Throughput: both handshakes held high, one result every WORDS+2 cycles.
    begin
      logic [W:0] q[$];
      int results = 0;
      int last_cyc = -1;
      logic sub;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int cyc = 0; cyc < 400 && results < 20; cyc++) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            check("tp_queue_empty", 1, 0);
          end else begin
            exp = q.pop_front();
            check("tp_sum", 64'(sum), 64'(exp[W-1:0]));
            check("tp_cout", cout, exp[W]);
          end
          if (last_cyc >= 0) check("tp_interval", 64'(cyc - last_cyc), 64'(WORDS + 2));
          last_cyc = cyc;
          results++;
          if (results == 20) in_valid = 1'b0;
        end
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'b0;
`ifdef RCA_SEQ_SUB_EN
        op  = 1'($urandom);
        sub = op;
`endif
        if (in_ready && in_valid) q.push_back(model(a, b, cin, sub));
        @(posedge clk);
        @(negedge clk);
      end
      check("tp_result_count", 64'(results), 20);
      out_ready = 1'b0;
      in_valid  = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
